// File: rtl/uart_rx_sipo_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    // parity_type encoding, shared with the transmitter
    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE1 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_error;
        logic       stop_error;
    } rx_result_t;

    function automatic logic parity_enabled(input logic [1:0] pt);
        return (pt == PAR_ODD) || (pt == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Serial line, configuration and received-frame status of the UART receiver.
interface uart_rx_sipo_if;

    logic       data_rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       active_flag;
    logic       done_flag;
    logic       parity_error;
    logic       stop_error;

    modport master (
        output data_rx, parity_type,
        input  data_out, active_flag, done_flag, parity_error, stop_error
    );

    modport slave (
        input  data_rx, parity_type,
        output data_out, active_flag, done_flag, parity_error, stop_error
    );

endinterface

// File: rtl/uart_rx_sipo_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start/8 data/optional parity/stop, mid-bit sampling,
// byte and error flags held until the next completed frame.
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic            baud_clk,
    input  logic            reset,
    uart_rx_sipo_if.slave   bus
);

    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    logic rxs;

    rx_state_t     state_q,  state_n;
    logic [TW-1:0] tick_q,   tick_n;
    logic [2:0]    bit_q,    bit_n;
    logic [7:0]    shreg_q,  shreg_n;
    logic [1:0]    ptype_q,  ptype_n;
    logic          perr_q,   perr_n;
    rx_result_t    result_q, result_n;
    logic          active_q, active_n;
    logic          done_q,   done_n;

    rx_sync u_sync (
        .clk (baud_clk),
        .rst (reset),
        .d   (bus.data_rx),
        .q   (rxs)
    );

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            ptype_q  <= PAR_NONE0;
            perr_q   <= 1'b0;
            result_q <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            tick_q   <= tick_n;
            bit_q    <= bit_n;
            shreg_q  <= shreg_n;
            ptype_q  <= ptype_n;
            perr_q   <= perr_n;
            result_q <= result_n;
            active_q <= active_n;
            done_q   <= done_n;
        end
    end

    // Each sampling state runs the tick counter and acts once at its sample point.
    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q + TW'(1);
        bit_n    = bit_q;
        shreg_n  = shreg_q;
        ptype_n  = ptype_q;
        perr_n   = perr_q;
        result_n = result_q;
        active_n = active_q;
        done_n   = 1'b0;

        case (state_q)
            IDLE: begin
                tick_n = '0;
                if (!rxs) begin
                    state_n  = START;
                    ptype_n  = bus.parity_type;
                    active_n = 1'b1;
                end
            end
            START: begin
                if (tick_q == TICK_MID) begin
                    tick_n = '0;
                    if (rxs) begin
                        // line went back high: glitch, not a start bit
                        state_n  = IDLE;
                        active_n = 1'b0;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
            end
            DATA: begin
                if (tick_q == TICK_END) begin
                    tick_n  = '0;
                    shreg_n = {rxs, shreg_q[7:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_n = parity_enabled(ptype_q) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick_q == TICK_END) begin
                    tick_n  = '0;
                    perr_n  = (ptype_q == PAR_EVEN) ? (^{shreg_q, rxs}) : ~(^{shreg_q, rxs});
                    state_n = STOP;
                end
            end
            STOP: begin
                if (tick_q == TICK_END) begin
                    tick_n                = '0;
                    state_n               = IDLE;
                    result_n.data         = shreg_q;
                    result_n.parity_error = parity_enabled(ptype_q) ? perr_q : 1'b0;
                    result_n.stop_error   = ~rxs;
                    done_n                = 1'b1;
                    active_n              = 1'b0;
                end
            end
            default: begin
                state_n  = IDLE;
                active_n = 1'b0;
            end
        endcase
    end

    assign bus.data_out     = result_q.data;
    assign bus.parity_error = result_q.parity_error;
    assign bus.stop_error   = result_q.stop_error;
    assign bus.active_flag  = active_q;
    assign bus.done_flag    = done_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Scoreboard bench for uart_rx_sipo: frames are queued with their expected result
// and checked by an independent monitor whenever done_flag is presented.
module tb_uart_rx_sipo;
    import uart_pkg::*;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
        int         lat;
    } exp_t;

    logic baud_clk = 1'b0;
    logic reset;

    uart_rx_sipo_if bus ();

    uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 baud_clk = ~baud_clk;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pushed    = 0;
    int   done_seen = 0;
    int   cycle     = 0;
    int   act_start = 0;
    logic prev_done = 1'b0;
    logic prev_act  = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", name, got, exp, cycle);
        end
    endtask

    always @(posedge baud_clk) cycle++;

    // Monitor: pops one expectation per done_flag pulse.
    always @(negedge baud_clk) begin
        if (reset) begin
            prev_done = 1'b0;
            prev_act  = 1'b0;
        end else begin
            if (bus.active_flag && !prev_act) act_start = cycle;
            if (bus.done_flag) begin
                done_seen++;
                check("done_single_cycle", 32'(prev_done), 32'(0));
                check("active_low_at_done", 32'(bus.active_flag), 32'(0));
                check("expected_frame_pending", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("data_out", 32'(bus.data_out), 32'(mon_e.d));
                    check("parity_error", 32'(bus.parity_error), 32'(mon_e.pe));
                    check("stop_error", 32'(bus.stop_error), 32'(mon_e.se));
                    check("done_latency", 32'(cycle - act_start), 32'(mon_e.lat));
                end
            end
            prev_done = bus.done_flag;
            prev_act  = bus.active_flag;
        end
    end

    task automatic hold_line(input logic v, input int n);
        bus.data_rx = v;
        repeat (n) @(posedge baud_clk);
        #1;
    endtask

    // Reference: error rules from ones-count parity; latency is half a bit plus whole bits.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                              input logic stop_bit, input int gap, input bit scramble);
        exp_t e;
        bit   pen;
        int   ones;
        pen   = (pt == PAR_ODD) || (pt == PAR_EVEN);
        ones  = $countones(d) + (pbit ? 1 : 0);
        e.d   = d;
        e.pe  = pen ? ((pt == PAR_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0)) : 1'b0;
        e.se  = (stop_bit == 1'b0);
        e.lat = OS / 2 + OS * (pen ? 10 : 9);
        sb.push_back(e);
        pushed++;
        bus.parity_type = pt;
        hold_line(1'b0, OS);
        if (scramble) bus.parity_type = 2'($urandom);
        for (int i = 0; i < 8; i++) hold_line(d[i], OS);
        if (pen) hold_line(pbit, OS);
        hold_line(stop_bit, OS);
        if (gap > 0) hold_line(1'b1, gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge baud_clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int done_before;
        logic [7:0] v55;
        reset           = 1'b1;
        bus.data_rx     = 1'b1;
        bus.parity_type = PAR_NONE0;
        repeat (5) @(posedge baud_clk);
        #1;
        check("reset_data_out", 32'(bus.data_out), 32'(0));
        check("reset_active", 32'(bus.active_flag), 32'(0));
        check("reset_done", 32'(bus.done_flag), 32'(0));
        check("reset_perr", 32'(bus.parity_error), 32'(0));
        check("reset_serr", 32'(bus.stop_error), 32'(0));
        reset = 1'b0;
        hold_line(1'b1, 4);

        send_frame(8'hA5, PAR_NONE0, 1'b0, 1'b1, 2 * OS, 1'b0);
        send_frame(8'h3C, PAR_EVEN, 1'b0, 1'b1, 2 * OS, 1'b0);
        send_frame(8'h3C, PAR_EVEN, 1'b1, 1'b1, 2 * OS, 1'b0);
        send_frame(8'h81, PAR_ODD, 1'b1, 1'b0, 3 * OS, 1'b0);
        drain();

        // Short low glitch must be rejected at the mid-bit check.
        done_before = done_seen;
        hold_line(1'b0, 4);
        hold_line(1'b1, 3 * OS);
        check("glitch_no_done", 32'(done_seen), 32'(done_before));
        check("glitch_data_hold", 32'(bus.data_out), 32'(8'h81));
        check("glitch_serr_hold", 32'(bus.stop_error), 32'(1));
        check("glitch_idle", 32'(bus.active_flag), 32'(0));

        // Reset in the middle of bit 4 of 0x55; the partial byte must vanish.
        v55             = 8'h55;
        bus.parity_type = PAR_NONE0;
        hold_line(1'b0, OS);
        for (int i = 0; i < 4; i++) hold_line(v55[i], OS);
        hold_line(v55[4], OS / 2);
        reset = 1'b1;
        repeat (3) @(posedge baud_clk);
        #1;
        check("midframe_reset_data", 32'(bus.data_out), 32'(0));
        check("midframe_reset_active", 32'(bus.active_flag), 32'(0));
        bus.data_rx = 1'b1;
        reset       = 1'b0;
        hold_line(1'b1, 2 * OS);
        send_frame(8'h0F, PAR_NONE0, 1'b0, 1'b1, 2 * OS, 1'b0);

        // Back-to-back frames with no idle time between stop and start.
        send_frame(8'h12, PAR_NONE0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h34, PAR_NONE1, 1'b0, 1'b1, 2 * OS, 1'b0);
        drain();

        for (int n = 0; n < 30; n++) begin
            logic       stop_bit;
            int         gap;
            stop_bit = ($urandom % 6) != 0;
            gap      = stop_bit ? int'($urandom % 40) : 2 * OS + int'($urandom % 16);
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), stop_bit, gap, 1'($urandom));
        end
        hold_line(1'b1, 2 * OS);
        drain();
        check("done_count", 32'(done_seen), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule
